spi_master_tx: RTL

//  SPI mode-0 master (CPOL=0, CPHA=0), MSB first. Drives the synth's SPI slave command port
//  (spi_clk/mosi/ss/miso) from an on-chip sequencer or test controller.

---
 rtl/spi_master_tx.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter/receiver (CPOL=0, CPHA=0), MSB first.
// Bytes arrive on a valid/ready port. i_tx_last closes the SS-low frame after
// the byte it accompanies. MISO is captured in full duplex and each received
// byte is presented with a one-cycle strobe.
module spi_master_tx #(
  parameter int CLK_DIV   = 5,
  parameter int FRAME_GAP = 4
) (
  input  logic       i_clk50mhz,
  input  logic       i_rst_n,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  input  logic       i_tx_last,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_busy,
  output logic       o_spi_clk,
  output logic       o_spi_mosi,
  input  logic       i_spi_miso,
  output logic       o_spi_ss
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(FRAME_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_WAIT  = 3'd2,
    ST_TRAIL = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Reset synchroniser: assertion is immediate, release is aligned to the clock.
  logic rst_meta_q, rst_meta_d;
  logic rst_sync_q, rst_sync_d;
  logic rst_n_s;

  // Reset synchroniser next values: shift a one in after i_rst_n releases.
  always_comb begin
    rst_meta_d = 1'b1;
    rst_sync_d = rst_meta_q;
  end

  // Reset synchroniser flops, cleared asynchronously by the external reset.
  always_ff @(posedge i_clk50mhz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= rst_meta_d;
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n_s = rst_sync_q;

  // Two-stage MISO synchroniser; only miso_s2_q is used by the shifter.
  logic miso_s1_q, miso_s1_d;
  logic miso_s2_q, miso_s2_d;

  // MISO synchroniser next values.
  always_comb begin
    miso_s1_d = i_spi_miso;
    miso_s2_d = miso_s1_q;
  end

  // MISO synchroniser flops.
  always_ff @(posedge i_clk50mhz or negedge rst_n_s) begin
    if (!rst_n_s) begin
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      miso_s1_q <= miso_s1_d;
      miso_s2_q <= miso_s2_d;
    end
  end

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      tx_sh_q, tx_sh_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic            last_q, last_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            ss_q, ss_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            accept_s;

  assign accept_s = i_tx_valid && ready_q;

  // Next-state and output logic: SCLK generation, shifting and framing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    last_d     = last_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    ss_d       = ss_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_WAIT: begin
        if (accept_s) begin
          state_d = ST_SHIFT;
          tx_sh_d = i_tx_data;
          last_d  = i_tx_last;
          mosi_d  = i_tx_data[7];
          ss_d    = 1'b0;
          sclk_d  = 1'b0;
          cnt_d   = {CW{1'b0}};
          bit_d   = 3'd0;
          rx_sh_d = 8'h00;
        end else begin
          state_d = state_q;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = {CW{1'b0}};
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            // Rising edge: sample the slave's bit.
            rx_sh_d = {rx_sh_q[6:0], miso_s2_q};
          end else if (bit_q == 3'd7) begin
            // Eighth falling edge: byte complete, MOSI keeps bit0.
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            bit_d      = 3'd0;
            state_d    = last_q ? ST_TRAIL : ST_WAIT;
          end else begin
            // Falling edge: present the next bit.
            bit_d   = bit_q + 3'd1;
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
            mosi_d  = tx_sh_q[6];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_TRAIL: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = {CW{1'b0}};
          gap_d   = {GW{1'b0}};
          ss_d    = 1'b1;
          mosi_d  = 1'b0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ss_d    = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase

    ready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and datapath registers; every output is driven from a flop.
  always_ff @(posedge i_clk50mhz or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CW{1'b0}};
      gap_q      <= {GW{1'b0}};
      bit_q      <= 3'd0;
      tx_sh_q    <= 8'h00;
      rx_sh_q    <= 8'h00;
      last_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ss_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      last_q     <= last_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      ss_q       <= ss_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign o_tx_ready = ready_q;
  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
  assign o_busy     = busy_q;
  assign o_spi_clk  = sclk_q;
  assign o_spi_mosi = mosi_q;
  assign o_spi_ss   = ss_q;

endmodule
